mux2x1_arbiter: RTL and testbench
=================================

MUX2X1_ARBITER -- requirements
Module: mux2x1_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of both sources and the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0  input  1  requester 0 has valid data on a.
REQ-005 a  input  WIDTH  requester 0 data.
REQ-006 req1  input  1  requester 1 has valid data on b.
REQ-007 b  input  WIDTH  requester 1 data.
REQ-008 gnt0  output  1  combinational; transfer from requester 0 occurs on the edge where req0 & gnt0.
REQ-009 gnt1  output  1  combinational; transfer from requester 1 occurs on the edge where req1 & gnt1.
REQ-010 sel  output  1  combinational mux select; 0 = a, 1 = b; drives the internal 2:1 data mux.
REQ-011 y  output  WIDTH  registered output data.
REQ-012 y_valid  output  1  y holds an unconsumed word.
REQ-013 y_ready  input  1  consumer accepts y on the edge where y_valid & y_ready.
REQ-014 y_src  output  1  registered; source of the word in y (0 = a, 1 = b).

Function
REQ-015 States: EMPTY (y_valid=0) and FULL (y_valid=1); y_valid is the state bit.
REQ-016 Slot open = EMPTY, or FULL with y_ready=1.
REQ-017 Slot open with req0 only: gnt0=1, sel=0. With req1 only: gnt1=1, sel=1.
REQ-018 Slot open with both requests: grant the requester opposite to register last; sel follows the grant.
REQ-019 No request or slot closed: gnt0=gnt1=0; sel holds its registered value (last), with no glitch-driven capture.
REQ-020 gnt0 and gnt1 are never both 1.
REQ-021 On a grant edge: y <= mux(a,b,sel), y_src <= sel, last <= sel, state -> FULL.
REQ-022 FULL with y_ready=1 and no grant: state -> EMPTY; y retains its value.
REQ-023 FULL with y_ready=0: y, y_src, y_valid stable; no grants issued (backpressure).
REQ-024 Drain and grant in the same cycle: new word captured; y_valid stays 1, giving full throughput of one word per cycle.
REQ-025 Latency: one cycle from grant edge to y_valid/y showing the word.
REQ-026 Continuous req0 and req1 with y_ready=1: grants strictly alternate 0,1,0,1...
REQ-027 last updates only on grant edges; a single active requester may be granted on consecutive cycles.
REQ-028 Requests are not latched; dropping req before a grant is legal and loses nothing.

Reset
REQ-029 rst=1 at a clock edge: y_valid=0, y=0, y_src=0, last=1 (requester 0 wins first tie).
REQ-030 While rst=1: gnt0=gnt1=0 and no capture occurs.
REQ-031 Reset mid-transfer discards any held word; the first grant after rst falls follows REQ-017/018.

Structure
REQ-032 Shared package mux2x1_pkg holds the state encoding (EMPTY=0, FULL=1), the source encoding (SRC_A=0, SRC_B=1), and default WIDTH.
REQ-033 The data path instantiates one sub-module, mux2x1 (WIDTH-wide 2:1 mux, select sel); the arbitration and register logic stay in mux2x1_arbiter.

Verification
REQ-034 Reset then idle: req0=req1=0 for 5 cycles -> gnt0=gnt1=0, y_valid=0, y=0, sel=1.
REQ-035 Single requester: req0=1, a=8'h3C, y_ready=1 -> gnt0=1; next cycle y=8'h3C, y_valid=1, y_src=0.
REQ-036 Tie and fairness: req0=req1=1 held with a=8'hAA, b=8'h55, y_ready=1 for 4 cycles -> y sequence AA,55,AA,55; y_src 0,1,0,1.
REQ-037 Backpressure: FULL with y=8'hAA, y_ready=0 for 3 cycles, req1=1 -> gnt0=gnt1=0, y=8'hAA stable; y_ready=1 -> gnt1=1 same cycle, y=8'h55 next cycle.
REQ-038 Mid-operation reset: FULL with y=8'h55, y_src=1, rst pulsed one cycle -> y_valid=0, y=0; then req0=req1=1 -> gnt0 first.
REQ-039 Exhaustive select check: all 8 (sel-pick, a-bit, b-bit) combinations at WIDTH=1 -> y equals the selected source bit after one cycle.

Source files
------------

// File: rtl/mux2x1_pkg.sv
// rtl/mux2x1_pkg.sv - shared encodings and defaults for the 2:1 arbitrated mux
package mux2x1_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // y_valid is the state bit itself
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

endpackage

// File: rtl/mux2x1.sv
// rtl/mux2x1.sv - WIDTH-wide 2:1 data mux, sel=0 picks a, sel=1 picks b
module mux2x1
  import mux2x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2x1_arbiter.sv
// rtl/mux2x1_arbiter.sv - two-requester round-robin arbiter feeding a one-word output register
module mux2x1_arbiter
  import mux2x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a,
  input  logic             req1,
  input  logic [WIDTH-1:0] b,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_src
);

  state_t           state_q, state_d;
  src_t             last_q;
  src_t             y_src_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] mux_y;
  logic             slot_open;
  logic             grant;

  mux2x1 #(.WIDTH(WIDTH)) u_mux (
    .a  (a),
    .b  (b),
    .sel(sel),
    .y  (mux_y)
  );

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    sel       = last_q;
    state_d   = state_q;
    slot_open = (state_q == EMPTY) || y_ready;

    // On a tie, requester 0 wins only if requester 1 took the previous grant
    if (!rst && slot_open) begin
      if (req0 && (!req1 || last_q == SRC_B)) begin
        gnt0 = 1'b1;
        sel  = SRC_A;
      end else if (req1) begin
        gnt1 = 1'b1;
        sel  = SRC_B;
      end
    end

    grant = gnt0 | gnt1;
    if (grant) begin
      state_d = FULL;
    end else if (state_q == FULL && y_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= SRC_B;
      y_q     <= '0;
      y_src_q <= SRC_A;
    end else begin
      state_q <= state_d;
      if (grant) begin
        y_q     <= mux_y;
        y_src_q <= src_t'(sel);
        last_q  <= src_t'(sel);
      end
    end
  end

  assign y       = y_q;
  assign y_src   = y_src_q;
  assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// tb/tb_mux2x1_arbiter.sv - scoreboard bench for mux2x1_arbiter
module tb_mux2x1_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, y_ready;
  logic [7:0] a, b;
  logic       gnt0, gnt1, sel, y_valid, y_src;
  logic [7:0] y;

  logic       req0_w1, req1_w1, y_ready_w1;
  logic [0:0] a_w1, b_w1, y_w1;
  logic       gnt0_w1, gnt1_w1, sel_w1, y_valid_w1, y_src_w1;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux2x1_arbiter #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .a(a), .req1(req1), .b(b),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .y(y), .y_valid(y_valid),
    .y_ready(y_ready), .y_src(y_src)
  );

  mux2x1_arbiter #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .req0(req0_w1), .a(a_w1), .req1(req1_w1), .b(b_w1),
    .gnt0(gnt0_w1), .gnt1(gnt1_w1), .sel(sel_w1), .y(y_w1), .y_valid(y_valid_w1),
    .y_ready(y_ready_w1), .y_src(y_src_w1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && y_valid && y_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got word %0h expected none", y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_y", {24'h0, y}, {24'h0, e.d});
        chk("sb_src", {31'h0, y_src}, {31'h0, e.s});
      end
    end
  end

  // One cycle: drive at posedge+1, check combinational grant/sel at negedge
  task automatic cyc(input logic r0, input logic r1, input logic [7:0] av, input logic [7:0] bv,
                     input logic rdy, input logic eg0, input logic eg1, input logic esel);
    req0 = r0; req1 = r1; a = av; b = bv; y_ready = rdy;
    @(negedge clk);
    chk("gnt0", {31'h0, gnt0}, {31'h0, eg0});
    chk("gnt1", {31'h0, gnt1}, {31'h0, eg1});
    chk("sel", {31'h0, sel}, {31'h0, esel});
    if (eg0) sb.push_back('{d: av, s: 1'b0});
    if (eg1) sb.push_back('{d: bv, s: 1'b1});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; a = '0; b = '0; y_ready = 1'b0;
    req0_w1 = 1'b0; req1_w1 = 1'b0; a_w1 = '0; b_w1 = '0; y_ready_w1 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b1;
    @(negedge clk);
    chk("rst_gnt0", {31'h0, gnt0}, 32'h0);
    chk("rst_gnt1", {31'h0, gnt1}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_y_valid", {31'h0, y_valid}, 32'h0);
    chk("rst_y", {24'h0, y}, 32'h0);
    chk("rst_y_src", {31'h0, y_src}, 32'h0);
    rst = 1'b0;

    repeat (5) begin
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("idle_y_valid", {31'h0, y_valid}, 32'h0);
      chk("idle_y", {24'h0, y}, 32'h0);
    end

    cyc(1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("single_y", {24'h0, y}, 32'h3C);
    chk("single_y_valid", {31'h0, y_valid}, 32'h1);
    chk("single_y_src", {31'h0, y_src}, 32'h0);
    cyc(1'b1, 1'b0, 8'h3D, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("repeat_y", {24'h0, y}, 32'h3D);
    cyc(1'b0, 1'b1, 8'h00, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1);

    repeat (2) begin
      cyc(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("tie_y_a", {24'h0, y}, 32'hAA);
      cyc(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("tie_y_b", {24'h0, y}, 32'h55);
    end

    cyc(1'b1, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      cyc(1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp_y", {24'h0, y}, 32'hAA);
      chk("bp_y_valid", {31'h0, y_valid}, 32'h1);
    end
    cyc(1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("bp_release_y", {24'h0, y}, 32'h55);
    chk("bp_release_src", {31'h0, y_src}, 32'h1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold_y_valid", {31'h0, y_valid}, 32'h1);

    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; a = 8'h11; b = 8'h22; y_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_gnt0", {31'h0, gnt0}, 32'h0);
    chk("midrst_gnt1", {31'h0, gnt1}, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_y_valid", {31'h0, y_valid}, 32'h0);
    chk("midrst_y", {24'h0, y}, 32'h0);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("drain_y_valid", {31'h0, y_valid}, 32'h0);
    chk("drain_y_keep", {24'h0, y}, 32'h11);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic       pick;
      v = 3'(i);
      pick = v[2];
      req0_w1 = ~pick; req1_w1 = pick; a_w1 = v[1]; b_w1 = v[0];
      @(negedge clk);
      chk("w1_gnt", {30'h0, gnt1_w1, gnt0_w1}, {30'h0, pick, ~pick});
      @(posedge clk);
      #1;
      chk("w1_y", {31'h0, y_w1}, {31'h0, (pick ? v[0] : v[1])});
    end
    req0_w1 = 1'b0; req1_w1 = 1'b0;

    chk("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
